// File: rtl/gpio_wb_pkg.sv
// gpio_wb_pkg
// Shared definitions for the gpio_wb Wishbone GPIO controller:
//   - word-index localparams for the register map (wb_adr_i[4:2])
//   - ID register fields
//   - sel_to_mask(): expands a 4-bit Wishbone byte select into a 32-bit mask
package gpio_wb_pkg;

  localparam logic [2:0] ADR_DATA_IN    = 3'd0;
  localparam logic [2:0] ADR_DATA_OUT   = 3'd1;
  localparam logic [2:0] ADR_DIR        = 3'd2;
  localparam logic [2:0] ADR_TOGGLE     = 3'd3;
  localparam logic [2:0] ADR_RISE_EN    = 3'd4;
  localparam logic [2:0] ADR_FALL_EN    = 3'd5;
  localparam logic [2:0] ADR_IRQ_STATUS = 3'd6;
  localparam logic [2:0] ADR_ID         = 3'd7;

  localparam logic [15:0] GPIO_ID_MAGIC = 16'h6770;
  localparam logic [7:0]  GPIO_VERSION  = 8'h01;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_wb_debounce.sv
// gpio_wb_debounce
// Single-bit input filter. The output follows the input only after the input
// has differed from the output for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (output and counter clear to 0)
//   i_d      synchronised input sample
//   o_q      filtered value
module gpio_wb_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [15:0] r_cnt;
  logic        r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_d == r_q) begin
      // Any bounce back to the current value restarts the stability window.
      r_cnt <= '0;
    end else if (r_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
      r_q   <= i_d;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gpio_wb.sv
// gpio_wb
// Wishbone B3 classic slave GPIO controller with per-pin direction, data-out,
// atomic toggle, synchronised input, and rising/falling edge interrupt capture.
// Optional input filter: define GPIO_DEBOUNCE_EN to insert gpio_wb_debounce
// per pin after the two-flop synchroniser.
// Ports:
//   wb_clk_i, wb_rst_n_i           clock, synchronous active-low reset
//   wb_adr_i[4:0]                  byte address (bits [1:0] ignored)
//   wb_dat_i/wb_dat_o[31:0]        write / registered read data
//   wb_sel_i[3:0]                  byte lane enables (gate every write)
//   wb_we_i, wb_cyc_i, wb_stb_i    bus controls
//   wb_ack_o                       one-cycle acknowledge
//   gpio_i                         asynchronous pad inputs
//   gpio_o, gpio_oe_o              pad output value / enable (1 = drive)
//   irq_o                          level interrupt, OR of IRQ_STATUS
//
// Handshake: an access is accepted on any edge where cyc & stb are high and
// ack is low; that edge raises ack for exactly one cycle, commits any write,
// and registers read data so wb_dat_o is valid while ack is high. Each access
// therefore takes two cycles. Reset clears ack, aborting an access in flight.
module gpio_wb
  import gpio_wb_pkg::*;
#(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic [4:0]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam int W = GPIO_WIDTH;

  logic          r_ack;
  logic [31:0]   r_dat;
  logic [W-1:0]  r_data_out, r_dir, r_rise_en, r_fall_en, r_irq_status;
  logic [W-1:0]  r_s1, r_s2, r_p;

  logic          w_acc, w_wr, w_rd;
  logic [2:0]    w_idx;
  logic [31:0]   w_wmask, w_wdat_m, w_rdata;
  logic [W-1:0]  w_mask, w_wbits, w_f, w_set, w_clr;
  logic          w_unused;

  assign w_acc    = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_acc & wb_we_i;
  assign w_rd     = w_acc & ~wb_we_i;
  assign w_idx    = wb_adr_i[4:2];
  assign w_wmask  = sel_to_mask(wb_sel_i);
  assign w_wdat_m = wb_dat_i & w_wmask;
  // Only the low W bits are stored; upper data bits are dropped.
  assign w_mask   = w_wmask[W-1:0];
  assign w_wbits  = w_wdat_m[W-1:0];
  assign w_unused = ^{wb_adr_i[1:0], w_wmask, w_wdat_m};

`ifdef GPIO_DEBOUNCE_EN
  for (genvar gi = 0; gi < W; gi++) begin : g_db
    gpio_wb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk  (wb_clk_i),
      .i_rst_n(wb_rst_n_i),
      .i_d    (r_s2[gi]),
      .o_q    (w_f[gi])
    );
  end
`else
  assign w_f = r_s2;
  // DEBOUNCE_CYCLES is inert without the filter; this empty block only
  // references it so the unfiltered build accepts it silently.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_inert
  end
`endif

  // Edges are seen relative to the previous filtered value, so enabling a
  // pin never picks up an edge that happened before the enable.
  assign w_set = ((w_f & ~r_p) & r_rise_en) | ((~w_f & r_p) & r_fall_en);
  assign w_clr = (w_wr && (w_idx == ADR_IRQ_STATUS)) ? w_wbits : '0;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      ADR_DATA_IN:    w_rdata[W-1:0] = w_f;
      ADR_DATA_OUT:   w_rdata[W-1:0] = r_data_out;
      ADR_DIR:        w_rdata[W-1:0] = r_dir;
      ADR_RISE_EN:    w_rdata[W-1:0] = r_rise_en;
      ADR_FALL_EN:    w_rdata[W-1:0] = r_fall_en;
      ADR_IRQ_STATUS: w_rdata[W-1:0] = r_irq_status;
      ADR_ID:         w_rdata = {GPIO_ID_MAGIC, GPIO_VERSION, 8'(GPIO_WIDTH)};
      default:        w_rdata = '0;  // TOGGLE reads 0
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_data_out   <= '0;
      r_dir        <= '0;
      r_rise_en    <= '0;
      r_fall_en    <= '0;
      r_irq_status <= '0;
      r_s1         <= '0;
      r_s2         <= '0;
      r_p          <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : '0;
      r_s1  <= gpio_i;
      r_s2  <= r_s1;
      r_p   <= w_f;
      if (w_wr) begin
        case (w_idx)
          ADR_DATA_OUT: r_data_out <= (r_data_out & ~w_mask) | w_wbits;
          ADR_DIR:      r_dir      <= (r_dir & ~w_mask) | w_wbits;
          ADR_TOGGLE:   r_data_out <= r_data_out ^ w_wbits;
          ADR_RISE_EN:  r_rise_en  <= (r_rise_en & ~w_mask) | w_wbits;
          ADR_FALL_EN:  r_fall_en  <= (r_fall_en & ~w_mask) | w_wbits;
          default: ;
        endcase
      end
      // New edges win over a same-cycle write-1-to-clear.
      r_irq_status <= (r_irq_status & ~w_clr) | w_set;
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign gpio_o    = r_data_out;
  assign gpio_oe_o = r_dir;
  assign irq_o     = |r_irq_status;

endmodule

// File: tb/tb_gpio_wb.sv
// tb_gpio_wb
// Directed bench for gpio_wb (GPIO_WIDTH=8, DEBOUNCE_CYCLES=4): a register
// vector table with hand-computed results, then hand-written sequences for
// edge capture, W1C, the set/clear collision and (when built with
// GPIO_DEBOUNCE_EN) the input filter.
module tb_gpio_wb;

  localparam int D = `ifdef GPIO_DEBOUNCE_EN 4 `else 0 `endif;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_wb #(
    .GPIO_WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_dat_o  (dat_o),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_ack_o  (ack),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe),
    .irq_o     (irq)
  );

  typedef struct {
    logic [4:0]  adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [7:0]  exp_o;
    logic [7:0]  exp_oe;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One Wishbone access; returns read data sampled while ack is high.
  task automatic wb_xfer(input logic [4:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(negedge clk);
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    n = 0;
    while (n < 4) begin
      @(posedge clk); #1;
      n++;
      if (ack) break;
    end
    chk("ack_seen", 32'(ack), 32'd1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, rd);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    wb_xfer(a, 1'b1, d, s, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{5'h00, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[1]  = '{5'h04, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[2]  = '{5'h08, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[3]  = '{5'h0C, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[4]  = '{5'h10, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[5]  = '{5'h14, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[6]  = '{5'h18, 1'b0, 32'h0,        4'hF, 32'h0,        8'h00, 8'h00};
    vecs[7]  = '{5'h1C, 1'b0, 32'h0,        4'hF, 32'h67700108, 8'h00, 8'h00};
    vecs[8]  = '{5'h08, 1'b1, 32'hFF,       4'h1, 32'h0,        8'h00, 8'hFF};
    vecs[9]  = '{5'h04, 1'b1, 32'hA5,       4'h1, 32'h0,        8'hA5, 8'hFF};
    vecs[10] = '{5'h04, 1'b1, 32'h0,        4'h2, 32'h0,        8'hA5, 8'hFF};
    vecs[11] = '{5'h04, 1'b0, 32'h0,        4'hF, 32'hA5,       8'hA5, 8'hFF};
    vecs[12] = '{5'h0C, 1'b1, 32'h0F,       4'hF, 32'h0,        8'hAA, 8'hFF};
    vecs[13] = '{5'h04, 1'b0, 32'h0,        4'hF, 32'hAA,       8'hAA, 8'hFF};
    vecs[14] = '{5'h0C, 1'b1, 32'h100,      4'hF, 32'h0,        8'hAA, 8'hFF};
    vecs[15] = '{5'h04, 1'b0, 32'h0,        4'hF, 32'hAA,       8'hAA, 8'hFF};
    vecs[16] = '{5'h0C, 1'b0, 32'h0,        4'hF, 32'h0,        8'hAA, 8'hFF};
    vecs[17] = '{5'h0C, 1'b1, 32'hFF,       4'h0, 32'h0,        8'hAA, 8'hFF};
    vecs[18] = '{5'h08, 1'b1, 32'h0F,       4'h1, 32'h0,        8'hAA, 8'h0F};
    vecs[19] = '{5'h08, 1'b0, 32'h0,        4'hF, 32'h0F,       8'hAA, 8'h0F};
    vecs[20] = '{5'h10, 1'b1, 32'h1FF,      4'h3, 32'h0,        8'hAA, 8'h0F};
    vecs[21] = '{5'h10, 1'b0, 32'h0,        4'hF, 32'hFF,       8'hAA, 8'h0F};
    vecs[22] = '{5'h10, 1'b1, 32'h0,        4'hF, 32'h0,        8'hAA, 8'h0F};
    vecs[23] = '{5'h10, 1'b0, 32'h0,        4'hF, 32'h0,        8'hAA, 8'h0F};
    vecs[24] = '{5'h04, 1'b1, 32'hFFFFFF3C, 4'hF, 32'h0,        8'h3C, 8'h0F};
    vecs[25] = '{5'h04, 1'b0, 32'h0,        4'hF, 32'h3C,       8'h3C, 8'h0F};

    // Clock/reset: reset held 3 cycles with a request pending.
    rst_n = 1'b0; adr = '0; dat_i = '0; sel = 4'hF; we = 1'b0;
    cyc = 1'b1; stb = 1'b1; gpio_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_ack", 32'(ack), 32'd0);
    end
    chk("rst_oe", 32'(gpio_oe), 32'd0);
    chk("rst_o", 32'(gpio_o), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;

    // Register table.
    for (int i = 0; i < NV; i++) begin
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, rd);
      if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_o", i), 32'(gpio_o), 32'(vecs[i].exp_o));
      chk($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
    end

    // Edge interrupt: pin 7 goes high before any enable.
    gpio_i = 8'h80;
    repeat (8 + D) @(posedge clk);
    rd_chk("pre_status", 5'h18, 32'h0);
    wr(5'h10, 32'h01, 4'hF);
    wr(5'h14, 32'h80, 4'hF);
    rd_chk("enable_no_past", 5'h18, 32'h0);

    @(posedge clk); #1 gpio_i = 8'h81;
    @(posedge clk); #1;  // edge k: first sample
    chk("irq_k", 32'(irq), 32'd0);
    @(posedge clk); #1;  // k+1
    chk("irq_k1", 32'(irq), 32'd0);
    repeat (2 + D) @(posedge clk);
    #1;                  // k+3 (+ filter)
    chk("irq_rise", 32'(irq), 32'd1);
    rd_chk("data_in_81", 5'h00, 32'h81);
    rd_chk("status_01", 5'h18, 32'h01);

    @(posedge clk); #1 gpio_i = 8'h01;
    repeat (6 + D) @(posedge clk);
    rd_chk("status_81", 5'h18, 32'h81);
    rd_chk("data_in_01", 5'h00, 32'h01);

    wr(5'h18, 32'h80, 4'h2);   // wrong lane: no clear
    rd_chk("w1c_sel_gated", 5'h18, 32'h81);
    wr(5'h18, 32'h01, 4'h1);
    rd_chk("w1c_bit0", 5'h18, 32'h80);
    chk("irq_still", 32'(irq), 32'd1);
    wr(5'h18, 32'h80, 4'h1);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("status_zero", 5'h18, 32'h0);

    // Collision: W1C of bit 0 lands on the edge that sets bit 0.
    gpio_i = 8'h00;
    repeat (6 + D) @(posedge clk);
    rd_chk("fall0_not_en", 5'h18, 32'h0);
    gpio_i = 8'h01;
    repeat (6 + D) @(posedge clk);
    rd_chk("prearm_01", 5'h18, 32'h01);
    gpio_i = 8'h00;
    repeat (6 + D) @(posedge clk);
    @(posedge clk); #1 gpio_i = 8'h01;        // after E0
    repeat (2 + D) @(posedge clk);           // E2 (+ filter)
    @(negedge clk);
    adr = 5'h18; we = 1'b1; dat_i = 32'h01; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;                      // set edge == ack edge
    chk("coll_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("coll_irq", 32'(irq), 32'd1);
    rd_chk("coll_status", 5'h18, 32'h01);
    wr(5'h18, 32'h01, 4'h1);
    rd_chk("post_coll_clear", 5'h18, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Filter: a 3-cycle pulse is rejected, a 6-cycle level passes.
    wr(5'h10, 32'h02, 4'h1);
    gpio_i = 8'h01;
    @(posedge clk); #1 gpio_i = 8'h03;
    repeat (3) @(posedge clk);
    #1 gpio_i = 8'h01;
    repeat (10) @(posedge clk);
    rd_chk("db_short_in", 5'h00, 32'h01);
    rd_chk("db_short_st", 5'h18, 32'h0);
    @(posedge clk); #1 gpio_i = 8'h03;
    repeat (6) @(posedge clk);
    rd_chk("db_long_in", 5'h00, 32'h03);
    rd_chk("db_long_st", 5'h18, 32'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_wb.md
Name: gpio_wb

Overview:
- Parametrised Wishbone B3 classic slave GPIO controller for picorv32_wb_soc board tops; next generation of the fixed 8-bit IO/LED hookup.
- Provides GPIO_WIDTH pins with a per-pin direction register, a data-out register, an atomic toggle register and a synchronised input.
- Adds per-pin rising/falling edge interrupt capture and a single level interrupt output.
- The board top owns the tristate: pad = gpio_oe_o[i] ? gpio_o[i] : 1'bz.

Parameters:
- GPIO_WIDTH, 8, number of pins; legal range 1..32.
- DEBOUNCE_CYCLES, 16, stable-sample count for the input filter; used only with GPIO_DEBOUNCE_EN; legal range 1..65535.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset.
- wb_adr_i  in  5  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte lane enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- gpio_i  in  GPIO_WIDTH  pad inputs, asynchronous.
- gpio_o  out  GPIO_WIDTH  pad output values.
- gpio_oe_o  out  GPIO_WIDTH  pad output enables; 1 = drive.
- irq_o  out  1  level interrupt.

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_n_i is synchronous and active-low.
- Reset values: all registers, synchronisers, wb_ack_o, wb_dat_o, gpio_o, gpio_oe_o and irq_o are 0, so all pins are inputs.
- Reset mid-transaction: ack is suppressed; the master must restart the cycle.
- Register map (word offsets):
  - 0x00 DATA_IN, RO.
  - 0x04 DATA_OUT, RW.
  - 0x08 DIR, RW.
  - 0x0C TOGGLE, WO: DATA_OUT ^= wdata; reads 0.
  - 0x10 RISE_EN, RW.
  - 0x14 FALL_EN, RW.
  - 0x18 IRQ_STATUS, RO / write-1-to-clear.
  - 0x1C ID, RO: {16'h6770, 8'h01, 8'(GPIO_WIDTH)}.
- Width rules: bits at and above GPIO_WIDTH are not stored, read 0 and ignore writes.
- Byte lanes: wb_sel_i gates every write per byte, including TOGGLE and W1C.
- Handshake:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o, giving a one-cycle pulse.
  - Read data is registered and valid with ack.
  - Writes take effect on the ack edge.
  - Back-to-back accesses therefore cost 2 cycles each.
  - No err/rty.
- Outputs: gpio_o = DATA_OUT; gpio_oe_o = DIR. Both update on the edge after the write is acked.
- Input path:
  - Chain s1 <= gpio_i, s2 <= s1, giving the filtered value f.
  - Without debounce, f = s2.
  - DATA_IN = f. A pin change sampled at edge k is readable from edge k+2 onward.
- Edge capture:
  - p <= f.
  - rise = f & ~p; fall = ~f & p.
  - IRQ_STATUS[i] is set at the edge after (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Enabling a pin does not capture past edges.
- Simultaneous set and clear: a set and a W1C on the same bit in the same cycle leaves the bit set.
- Interrupt output: irq_o = |IRQ_STATUS, combinational from flops. It drops on the edge after the last W1C. It is not masked by DIR, so output pins can self-interrupt.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- When defined:
  - Each pin has a 16-bit counter.
  - When s2 != f, the counter increments. It resets to 0 whenever s2 == f.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s2 still != f, f <= s2 and the counter clears.
  - A change must therefore persist DEBOUNCE_CYCLES cycles; latency is 2 + DEBOUNCE_CYCLES.
  - Reset: counters 0, f 0.
- When undefined: f = s2, no counters, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package gpio_wb_pkg holds:
  - register offset localparams: ADR_DATA_IN .. ADR_ID;
  - GPIO_ID_MAGIC = 16'h6770 and GPIO_VERSION = 8'h01;
  - a function that expands a 4-bit sel into a 32-bit byte mask.
- One sub-module, gpio_wb_debounce: a single-bit filter with a DEBOUNCE_CYCLES parameter, generated per pin under the macro.

Test Plan:
- Reset: hold wb_rst_n_i low 3 cycles with stb/cyc high. Required: wb_ack_o=0, gpio_oe_o=0, gpio_o=0, irq_o=0. After release, reads return 0 for 0x00..0x18 and ID = 32'h67700108.
- Byte lanes: write DIR=0xFF and DATA_OUT=0xA5 with sel=4'b0001. Required: gpio_oe_o=0xFF and gpio_o=0xA5 on the edge after ack. Then write DATA_OUT=0x00 with sel=4'b0010. Required: gpio_o stays 0xA5.
- Toggle: with DATA_OUT=0xA5, write TOGGLE=0x0F. Required: DATA_OUT reads 0xAA. Then write TOGGLE=0x100 on GPIO_WIDTH=8. Required: DATA_OUT stays 0xAA and a read returns 0x000000AA.
- Edge interrupt:
  - Setup: RISE_EN=0x01 and FALL_EN=0x80.
  - Drive gpio_i[0] 0->1 at edge k. Required: DATA_IN[0]=1 by k+2, IRQ_STATUS=0x01 and irq_o=1 at k+3.
  - Then drive gpio_i[7] 1->0. Required: IRQ_STATUS=0x81.
  - Write IRQ_STATUS=0x01. Required: status 0x80, irq_o still 1.
  - Write 0x80. Required: irq_o=0 on the next edge.
- Collision: issue a W1C of bit 0 in the same cycle a new rising edge on pin 0 is detected. Required: IRQ_STATUS[0] stays 1 and irq_o stays 1.
- Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): a 3-cycle high pulse on gpio_i[1] leaves DATA_IN[1]=0 and no status. A 6-cycle high makes DATA_IN[1]=1 at 2+4 cycles after the first sample.
